mdio_master: RTL and testbench
==============================

Name: mdio_master

Overview:
Parametrised successor to the team's MDIO controller. Generates IEEE 802.3 management frames (Clause 22 and optionally Clause 45) on an MDC/MDIO pair from one system clock. Adds a configurable MDC divider, preamble length and suppression, Clause 45 opcodes, and a turnaround error check. Sits between the register-access host logic and the PHY pad (tristate buffer is external, driven by mdio_out/mdio_oe).

Parameters:
CLK_DIV, 4, clk cycles per MDC half-period (MDC period = 2*CLK_DIV clk cycles); legal range 1..255.
PREAMBLE_LEN, 32, number of preamble '1' bits when preamble is enabled; legal range 1..63.
SUPPORT_C45, 1, 1 enables Clause 45 frames; 0 rejects every c45=1 request.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  request strobe; sampled only in IDLE.
c45  input  1  0 = Clause 22 frame, 1 = Clause 45 frame.
op  input  2  frame OP field: C22 01 = write, 10 = read; C45 00 = address, 01 = write, 11 = read, 10 = post-read-increment read.
no_preamble  input  1  1 = omit the preamble.
phy_addr  input  5  PHYAD (C45: PRTAD).
reg_addr  input  5  REGAD (C45: DEVAD).
write_data  input  16  write data (C45 address frame: register address).
mdio_in  input  1  MDIO pad input.
mdio_out  output  1  MDIO drive value.
mdio_oe  output  1  1 = master drives MDIO.
mdc  output  1  management clock.
read_data  output  16  last successfully read data.
read_valid  output  1  1-cycle pulse, read_data updated.
error  output  1  1-cycle pulse with done: illegal request or TA error.
busy  output  1  frame in progress.
done  output  1  1-cycle pulse at end of request.

Behaviour:
- Reset (asynchronous, immediate, including mid-frame): mdc=0, mdio_oe=0, mdio_out=1, read_data=0, read_valid=0, error=0, busy=0, done=0, state=IDLE. The aborted frame does not complete and no pulse is generated.
- States: IDLE -> PRE -> ST -> OP -> PA -> RA -> TA -> DATA -> FIN -> IDLE.
- IDLE: mdc=0, mdio_oe=0. When start=1, all request inputs are latched and busy=1 from the next cycle. Inputs are not observed again until IDLE.
- Illegal request: c45=0 with op 00 or 11, or c45=1 with SUPPORT_C45=0. No frame is sent and MDIO stays released. On the next cycle, done=1, error=1 and busy=0.
- start while busy is ignored.
- Bit timing: each bit is one MDC period, with the low half first and then the high half. mdc rises after CLK_DIV clk cycles of the bit. mdio_out/mdio_oe change only on the clk cycle where the low half begins. mdio_in is sampled on the clk cycle where mdc rises.
- PRE: PREAMBLE_LEN ones, driven. This state is skipped when no_preamble=1.
- ST: C22 drives 01, C45 drives 00.
- OP: op[1] then op[0].
- PA, RA: MSB first.
- TA, write/address frames: drive 1 then 0.
- TA, read frames (C22 10, C45 11/10): mdio_oe=0 for both TA bits and all 16 DATA bits. If the second TA sample is 1, the TA error flag is set.
- DATA, write: write_data MSB first, driven.
- DATA, read: 16 samples are shifted in MSB first.
- FIN: one extra MDC period with mdc toggling, mdio_oe=0, mdio_out=1.
- Frame length in clk cycles: (P + 32 + 1) * 2 * CLK_DIV, where P = 0 or PREAMBLE_LEN.
- On the cycle after FIN ends: done=1 and busy=0.
  - Read without TA error: read_data is loaded and read_valid=1 in the same cycle.
  - Read with TA error: read_data is unchanged, read_valid=0, error=1.
- One request can be accepted on the cycle after done.

Test Plan:
- C22 write, phy=1, reg=2, data=ABCD, CLK_DIV=4 -> mdio_out samples at mdc rises are 32 ones, then 01 01 00001 00010 10 1010101111001101. busy lasts 65*8=520 clk cycles, then done=1, error=0, mdio_oe=0 during FIN.
- C22 read, phy=3, reg=4, PHY model drives TA0=0 and data 1234 after each mdc rise -> mdio_oe=0 from the first TA bit; read_data=1234 and read_valid=1 with done.
- C22 read with mdio_in held at 1 -> done=1, error=1, read_valid=0, read_data keeps the previous value (1234).
- no_preamble=1, C45 address frame, prtad=5, devad=1, data=0010 -> ST=00 and OP=00 are first on the wire; busy lasts 33*8=264 cycles. The same request with SUPPORT_C45=0 -> done plus error on the next cycle and no mdc toggling.
- Illegal C22 op=11 -> error=1 and done=1 one cycle after start; start pulsed during a write frame -> ignored, and the frame bitstream is unchanged.
- Reset asserted low mid-DATA of a write -> mdc=0, mdio_oe=0 and busy=0 immediately with no done. After release, a new C22 read completes normally.

Source files
------------

// File: rtl/mdio_master_if.sv
// Host/PHY-side bundle for mdio_master.
// DUT connects through slave, host-side logic through master.
interface mdio_master_if;
  logic        start;
  logic        c45;
  logic [1:0]  op;
  logic        no_preamble;
  logic [4:0]  phy_addr;
  logic [4:0]  reg_addr;
  logic [15:0] write_data;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oe;
  logic        mdc;
  logic [15:0] read_data;
  logic        read_valid;
  logic        error;
  logic        busy;
  logic        done;

  modport slave (
    input  start, c45, op, no_preamble,
    input  phy_addr, reg_addr, write_data,
    input  mdio_in,
    output mdio_out, mdio_oe, mdc,
    output read_data, read_valid,
    output error, busy, done
  );

  modport master (
    output start, c45, op, no_preamble,
    output phy_addr, reg_addr, write_data,
    output mdio_in,
    input  mdio_out, mdio_oe, mdc,
    input  read_data, read_valid,
    input  error, busy, done
  );
endinterface

// File: rtl/mdio_master.sv
// MDIO management frame master (Clause 22, optional Clause 45).
// One bit per MDC period: drive on low-half start, sample on mdc rise.
module mdio_master #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned PREAMBLE_LEN = 32,
  parameter bit          SUPPORT_C45  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  mdio_master_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, PRE, ST, OP, PA, RA, TA, DATA, FIN
  } state_e;

  localparam logic [8:0] HALF    = 9'(CLK_DIV - 1);
  localparam logic [8:0] LAST    = 9'(2 * CLK_DIV - 1);
  localparam logic [5:0] PRE_TOP = 6'(PREAMBLE_LEN - 1);

  state_e      state_q, state_d, ns;
  logic [8:0]  div_q, div_d;
  logic [5:0]  bit_q, bit_d, nb;
  logic        c45_q, c45_d;
  logic [1:0]  op_q, op_d;
  logic        rd_q, rd_d;
  logic [4:0]  pa_q, pa_d;
  logic [4:0]  ra_q, ra_d;
  logic [15:0] wd_q, wd_d;
  logic [15:0] sh_q, sh_d;
  logic        taerr_q, taerr_d;
  logic        mdc_q, mdc_d;
  logic        out_q, out_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        rv_q, rv_d;
  logic [15:0] rdata_q, rdata_d;
  logic        illegal;

  function automatic logic [5:0] top_of(state_e s);
    case (s)
      PRE:        return PRE_TOP;
      ST, OP, TA: return 6'd1;
      PA, RA:     return 6'd4;
      DATA:       return 6'd15;
      default:    return 6'd0;
    endcase
  endfunction

  function automatic state_e next_of(state_e s);
    case (s)
      PRE:     return ST;
      ST:      return OP;
      OP:      return PA;
      PA:      return RA;
      RA:      return TA;
      TA:      return DATA;
      DATA:    return FIN;
      default: return IDLE;
    endcase
  endfunction

  assign illegal = bus.c45 ? !SUPPORT_C45
                 : (bus.op == 2'b00 || bus.op == 2'b11);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    c45_d   = c45_q;
    op_d    = op_q;
    rd_d    = rd_q;
    pa_d    = pa_q;
    ra_d    = ra_q;
    wd_d    = wd_q;
    sh_d    = sh_q;
    taerr_d = taerr_q;
    mdc_d   = mdc_q;
    out_d   = out_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rv_d    = 1'b0;
    rdata_d = rdata_q;
    ns      = state_q;
    nb      = bit_q;
    if (state_q == IDLE) begin
      mdc_d = 1'b0;
      oe_d  = 1'b0;
      out_d = 1'b1;
      if (bus.start) begin
        if (illegal) begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end else begin
          c45_d   = bus.c45;
          op_d    = bus.op;
          rd_d    = bus.op[1];
          pa_d    = bus.phy_addr;
          ra_d    = bus.reg_addr;
          wd_d    = bus.write_data;
          taerr_d = 1'b0;
          busy_d  = 1'b1;
          div_d   = 9'd0;
          oe_d    = 1'b1;
          if (bus.no_preamble) begin
            state_d = ST;
            bit_d   = 6'd1;
            out_d   = 1'b0;
          end else begin
            state_d = PRE;
            bit_d   = PRE_TOP;
          end
        end
      end
    end else begin
      div_d = div_q + 9'd1;
      if (div_q == HALF) begin
        mdc_d = 1'b1;
        if (rd_q && state_q == TA && bit_q == 6'd0)
          taerr_d = bus.mdio_in;
        if (rd_q && state_q == DATA)
          sh_d = {sh_q[14:0], bus.mdio_in};
      end
      if (div_q == LAST) begin
        div_d = 9'd0;
        mdc_d = 1'b0;
        if (bit_q == 6'd0) begin
          ns = next_of(state_q);
          nb = top_of(ns);
        end else begin
          nb = bit_q - 6'd1;
        end
        state_d = ns;
        bit_d   = nb;
        oe_d    = 1'b1;
        out_d   = 1'b1;
        // Value placed here is the one for the bit about to start.
        case (ns)
          PRE:  out_d = 1'b1;
          ST:   out_d = ~c45_q & ~nb[0];
          OP:   out_d = op_q[nb[0]];
          PA:   out_d = pa_q[nb[2:0]];
          RA:   out_d = ra_q[nb[2:0]];
          TA: begin
            if (rd_q) oe_d = 1'b0;
            else      out_d = nb[0];
          end
          DATA: begin
            if (rd_q) oe_d = 1'b0;
            else      out_d = wd_q[nb[3:0]];
          end
          default: oe_d = 1'b0;
        endcase
        if (ns == IDLE) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          if (rd_q && taerr_q) begin
            err_d = 1'b1;
          end else if (rd_q) begin
            rv_d    = 1'b1;
            rdata_d = sh_q;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      c45_q   <= 1'b0;
      op_q    <= '0;
      rd_q    <= 1'b0;
      pa_q    <= '0;
      ra_q    <= '0;
      wd_q    <= '0;
      sh_q    <= '0;
      taerr_q <= 1'b0;
      mdc_q   <= 1'b0;
      out_q   <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      c45_q   <= c45_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      pa_q    <= pa_d;
      ra_q    <= ra_d;
      wd_q    <= wd_d;
      sh_q    <= sh_d;
      taerr_q <= taerr_d;
      mdc_q   <= mdc_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.mdc        = mdc_q;
  assign bus.mdio_out   = out_q;
  assign bus.mdio_oe    = oe_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = err_q;
  assign bus.read_valid = rv_q;
  assign bus.read_data  = rdata_q;
endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: wire-level scoreboard plus a simple PHY.
// Second instance covers builds without Clause 45.
module tb_mdio_master;
  localparam int PRE = 32;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mdio_master_if bus();
  mdio_master_if bus2();

  mdio_master #(
    .CLK_DIV(4), .PREAMBLE_LEN(PRE), .SUPPORT_C45(1'b1)
  ) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  mdio_master #(
    .CLK_DIV(4), .PREAMBLE_LEN(PRE), .SUPPORT_C45(1'b0)
  ) dut2 (
    .clk(clk), .reset(rst_n), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  exp_q[$];
  logic [1:0]  e;
  int          rise_cnt = 0;
  int          cur_p = PRE;
  logic [15:0] phy_word = '0;
  bit          phy_stuck = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic phy_val(input int r);
    int k;
    if (phy_stuck) return 1'b1;
    if (r == cur_p + 14 || r == cur_p + 15) return 1'b0;
    if (r >= cur_p + 16 && r <= cur_p + 31) begin
      k = cur_p + 31 - r;
      return phy_word[k];
    end
    return 1'b1;
  endfunction

  // Entries: 2'b1x = driven bit x, 2'b00 = released.
  always @(posedge bus.mdc) begin
    #1;
    if (exp_q.size() == 0) begin
      chk("unexp_mdc", 32'(bus.mdc), 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("oe", 32'(bus.mdio_oe), 32'(e[1]));
      if (e[1]) chk("bit", 32'(bus.mdio_out), 32'(e[0]));
    end
    rise_cnt++;
    bus.mdio_in = phy_val(rise_cnt);
  end

  task automatic push_frame(input bit np, input bit c,
                            input logic [1:0] o,
                            input logic [4:0] pa,
                            input logic [4:0] ra,
                            input logic [15:0] wd,
                            input bit rd);
    cur_p = np ? 0 : PRE;
    if (!np) repeat (PRE) exp_q.push_back(2'b11);
    exp_q.push_back(2'b10);
    exp_q.push_back(c ? 2'b10 : 2'b11);
    exp_q.push_back({1'b1, o[1]});
    exp_q.push_back({1'b1, o[0]});
    for (int i = 4; i >= 0; i--) exp_q.push_back({1'b1, pa[i]});
    for (int i = 4; i >= 0; i--) exp_q.push_back({1'b1, ra[i]});
    if (rd) begin
      exp_q.push_back(2'b00);
      exp_q.push_back(2'b00);
    end else begin
      exp_q.push_back(2'b11);
      exp_q.push_back(2'b10);
    end
    for (int i = 15; i >= 0; i--)
      exp_q.push_back(rd ? 2'b00 : {1'b1, wd[i]});
    exp_q.push_back(2'b00);
  endtask

  task automatic req(input bit np, input bit c,
                     input logic [1:0] o,
                     input logic [4:0] pa,
                     input logic [4:0] ra,
                     input logic [15:0] wd);
    @(negedge clk);
    bus.no_preamble = np;
    bus.c45         = c;
    bus.op          = o;
    bus.phy_addr    = pa;
    bus.reg_addr    = ra;
    bus.write_data  = wd;
    bus.start       = 1'b1;
    rise_cnt        = 0;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input bit poke, output int n);
    n = 0;
    while (bus.busy && n < 4000) begin
      if (poke && n == 100) begin
        bus.start      = 1'b1;
        bus.op         = 2'b10;
        bus.c45        = 1'b1;
        bus.phy_addr   = 5'h1f;
        bus.write_data = 16'hffff;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    chk("busy_timeout", 32'(bus.busy), 32'd0);
  endtask

  int n;
  int g;
  bit seen;

  initial begin
    bus.start = 0; bus.c45 = 0; bus.op = 0; bus.no_preamble = 0;
    bus.phy_addr = 0; bus.reg_addr = 0; bus.write_data = 0;
    bus.mdio_in = 1;
    bus2.start = 0; bus2.c45 = 0; bus2.op = 0; bus2.no_preamble = 0;
    bus2.phy_addr = 0; bus2.reg_addr = 0; bus2.write_data = 0;
    bus2.mdio_in = 1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mdc", 32'(bus.mdc), 0);
    chk("rst_oe", 32'(bus.mdio_oe), 0);
    chk("rst_out", 32'(bus.mdio_out), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_rdata", 32'(bus.read_data), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // C22 write with preamble
    push_frame(0, 0, 2'b01, 5'd1, 5'd2, 16'hABCD, 0);
    req(0, 0, 2'b01, 5'd1, 5'd2, 16'hABCD);
    wait_done(0, n);
    chk("w_len", n, 520);
    chk("w_done", 32'(bus.done), 1);
    chk("w_err", 32'(bus.error), 0);
    chk("w_rv", 32'(bus.read_valid), 0);
    chk("w_sb_left", exp_q.size(), 0);

    // C22 read, PHY answers 1234
    phy_word = 16'h1234; phy_stuck = 0;
    push_frame(0, 0, 2'b10, 5'd3, 5'd4, 16'h0, 1);
    req(0, 0, 2'b10, 5'd3, 5'd4, 16'h0);
    wait_done(0, n);
    chk("r_len", n, 520);
    chk("r_done", 32'(bus.done), 1);
    chk("r_err", 32'(bus.error), 0);
    chk("r_rv", 32'(bus.read_valid), 1);
    chk("r_data", 32'(bus.read_data), 32'h1234);

    // C22 read, no PHY (TA error)
    phy_stuck = 1;
    push_frame(0, 0, 2'b10, 5'd3, 5'd4, 16'h0, 1);
    req(0, 0, 2'b10, 5'd3, 5'd4, 16'h0);
    wait_done(0, n);
    chk("ta_done", 32'(bus.done), 1);
    chk("ta_err", 32'(bus.error), 1);
    chk("ta_rv", 32'(bus.read_valid), 0);
    chk("ta_data", 32'(bus.read_data), 32'h1234);
    phy_stuck = 0;

    // C45 address frame, no preamble
    push_frame(1, 1, 2'b00, 5'd5, 5'd1, 16'h0010, 0);
    req(1, 1, 2'b00, 5'd5, 5'd1, 16'h0010);
    wait_done(0, n);
    chk("c45a_len", n, 264);
    chk("c45a_done", 32'(bus.done), 1);
    chk("c45a_err", 32'(bus.error), 0);

    // C45 read, no preamble
    phy_word = 16'hC0DE;
    push_frame(1, 1, 2'b11, 5'd7, 5'd3, 16'h0, 1);
    req(1, 1, 2'b11, 5'd7, 5'd3, 16'h0);
    wait_done(0, n);
    chk("c45r_len", n, 264);
    chk("c45r_rv", 32'(bus.read_valid), 1);
    chk("c45r_data", 32'(bus.read_data), 32'hC0DE);

    // C45 on a build without Clause 45
    @(negedge clk);
    bus2.c45 = 1; bus2.op = 2'b00; bus2.no_preamble = 1;
    bus2.phy_addr = 5'd5; bus2.reg_addr = 5'd1;
    bus2.write_data = 16'h0010; bus2.start = 1;
    @(negedge clk);
    bus2.start = 0;
    chk("nc45_done", 32'(bus2.done), 1);
    chk("nc45_err", 32'(bus2.error), 1);
    chk("nc45_busy", 32'(bus2.busy), 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      seen |= bus2.mdc;
    end
    chk("nc45_mdc", 32'(seen), 0);

    // Illegal C22 op
    req(0, 0, 2'b11, 5'd1, 5'd1, 16'h0);
    chk("ill_done", 32'(bus.done), 1);
    chk("ill_err", 32'(bus.error), 1);
    chk("ill_busy", 32'(bus.busy), 0);
    repeat (20) @(negedge clk);
    chk("ill_oe", 32'(bus.mdio_oe), 0);

    // start poked mid-frame must be ignored
    push_frame(0, 0, 2'b01, 5'd9, 5'd17, 16'h5A5A, 0);
    req(0, 0, 2'b01, 5'd9, 5'd17, 16'h5A5A);
    wait_done(1, n);
    chk("poke_len", n, 520);
    chk("poke_err", 32'(bus.error), 0);
    chk("poke_sb_left", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("poke_idle", 32'(bus.busy), 0);

    // Reset mid-DATA of a write
    push_frame(0, 0, 2'b01, 5'd2, 5'd6, 16'hF00F, 0);
    req(0, 0, 2'b01, 5'd2, 5'd6, 16'hF00F);
    g = 0;
    while (rise_cnt < PRE + 20 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("rst_reach", 32'(rise_cnt >= PRE + 20), 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_mdc", 32'(bus.mdc), 0);
    chk("mrst_oe", 32'(bus.mdio_oe), 0);
    chk("mrst_busy", 32'(bus.busy), 0);
    chk("mrst_done", 32'(bus.done), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_nodone", 32'(bus.done), 0);

    // Read after reset
    phy_word = 16'hBEEF;
    push_frame(1, 0, 2'b10, 5'd1, 5'd2, 16'h0, 1);
    req(1, 0, 2'b10, 5'd1, 5'd2, 16'h0);
    wait_done(0, n);
    chk("pr_len", n, 264);
    chk("pr_rv", 32'(bus.read_valid), 1);
    chk("pr_data", 32'(bus.read_data), 32'hBEEF);
    chk("pr_sb_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
